reg_file_mp: RTL

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_pkg.sv | 20 ++
 rtl/reg_scoreboard.sv | 67 ++++++
 rtl/reg_file_mp.sv | 105 ++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the multi-port register file: default port counts
// and geometry, plus data/address types derived from those defaults.
// No ports (package).
// -----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 32;
  localparam int DEF_READ_PORT  = 4;
  localparam int DEF_WRITE_PORT = 2;
  localparam int DEF_ISSUE_PORT = 2;
  localparam int DEF_BYPASS     = 1;
  localparam int DEF_AW         = $clog2(DEF_DEPTH);

  typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;
  typedef logic [DEF_AW-1:0]         reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// One pending bit per register. Issues set a bit, writes clear it; when both
// name the same register in one cycle the issue wins (it is the newer
// producer). Busy is looked up per read port.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   set_addr_i/set_en_i issue ports (mark destination pending)
//   clr_addr_i/clr_en_i write ports (producer has delivered)
//   rd_addr_i           read addresses
//   busy_o              pending bit of each read address
// -----------------------------------------------------------------------------
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AW        = $clog2(DEPTH),
  parameter int READ_PORT = DEF_READ_PORT,
  parameter int CLR_PORT  = DEF_WRITE_PORT,
  parameter int SET_PORT  = DEF_ISSUE_PORT,
  parameter int BYPASS    = DEF_BYPASS
)(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SET_PORT-1:0][AW-1:0]   set_addr_i,
  input  logic [SET_PORT-1:0]           set_en_i,
  input  logic [CLR_PORT-1:0][AW-1:0]   clr_addr_i,
  input  logic [CLR_PORT-1:0]           clr_en_i,
  input  logic [READ_PORT-1:0][AW-1:0]  rd_addr_i,
  output logic [READ_PORT-1:0]          busy_o
);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Clears applied first so a same-cycle issue leaves the bit set.
  always_comb begin
    pend_d = pend_q;
    for (int p = 0; p < CLR_PORT; p++) begin
      if (clr_en_i[p]) pend_d[clr_addr_i[p]] = 1'b0;
    end
    for (int p = 0; p < SET_PORT; p++) begin
      if (set_en_i[p]) pend_d[set_addr_i[p]] = 1'b1;
    end
    pend_d[0] = 1'b0;  // register 0 never has a producer
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // With forwarding the in-flight write already supplies the value, so the
  // register is reported ready in that cycle.
  always_comb begin
    busy_o = '0;
    for (int r = 0; r < READ_PORT; r++) begin
      busy_o[r] = pend_q[rd_addr_i[r]];
      if (BYPASS != 0) begin
        for (int p = 0; p < CLR_PORT; p++) begin
          if (clr_en_i[p] && clr_addr_i[p] == rd_addr_i[r]) busy_o[r] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
// Multi-port register file with hard-wired zero register, optional same-cycle
// write-to-read forwarding, write-collision flag and a pending-producer
// scoreboard.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   r_addr_i / r_data_o          read ports (combinational data)
//   r_busy_o                     read-port pending status
//   w_addr_i / w_data_i / w_en_i write ports (highest index wins on collision)
//   iss_addr_i / iss_en_i        issue ports (mark destination pending)
//   conflict_o                   previous cycle had a nonzero write collision
// -----------------------------------------------------------------------------
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int READ_PORT  = DEF_READ_PORT,
  parameter int WRITE_PORT = DEF_WRITE_PORT,
  parameter int ISSUE_PORT = DEF_ISSUE_PORT,
  parameter int BYPASS     = DEF_BYPASS,
  localparam int AW        = $clog2(DEPTH)
)(
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [READ_PORT-1:0][AW-1:0]         r_addr_i,
  output logic [READ_PORT-1:0][DATA_WIDTH-1:0] r_data_o,
  output logic [READ_PORT-1:0]                 r_busy_o,
  input  logic [WRITE_PORT-1:0][AW-1:0]        w_addr_i,
  input  logic [WRITE_PORT-1:0][DATA_WIDTH-1:0] w_data_i,
  input  logic [WRITE_PORT-1:0]                w_en_i,
  input  logic [ISSUE_PORT-1:0][AW-1:0]        iss_addr_i,
  input  logic [ISSUE_PORT-1:0]                iss_en_i,
  output logic                                 conflict_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  conflict_q;
  logic                  conflict_d;

  // Ports are visited in ascending order, so the last nonblocking update
  // (highest port index) wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else begin
      for (int p = 0; p < WRITE_PORT; p++) begin
        if (w_en_i[p] && w_addr_i[p] != '0) mem_q[w_addr_i[p]] <= w_data_i[p];
      end
    end
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < WRITE_PORT; i++) begin
      for (int j = i + 1; j < WRITE_PORT; j++) begin
        if (w_en_i[i] && w_en_i[j] && w_addr_i[i] == w_addr_i[j] &&
            w_addr_i[i] != '0)
          conflict_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_q <= 1'b0;
    else        conflict_q <= conflict_d;
  end

  assign conflict_o = conflict_q;

  // Read path: stored value, overridden by the winning in-flight write when
  // forwarding is enabled; zero for register 0 and throughout reset.
  always_comb begin
    r_data_o = '0;
    for (int r = 0; r < READ_PORT; r++) begin
      r_data_o[r] = mem_q[r_addr_i[r]];
      if (BYPASS != 0) begin
        for (int p = 0; p < WRITE_PORT; p++) begin
          if (w_en_i[p] && w_addr_i[p] == r_addr_i[r]) r_data_o[r] = w_data_i[p];
        end
      end
      if (!rst_n || r_addr_i[r] == '0) r_data_o[r] = '0;
    end
  end

  reg_scoreboard #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .READ_PORT (READ_PORT),
    .CLR_PORT  (WRITE_PORT),
    .SET_PORT  (ISSUE_PORT),
    .BYPASS    (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_addr_i (iss_addr_i),
    .set_en_i   (iss_en_i),
    .clr_addr_i (w_addr_i),
    .clr_en_i   (w_en_i),
    .rd_addr_i  (r_addr_i),
    .busy_o     (r_busy_o)
  );

endmodule
